membus_avalon_master: RTL and testbench

- Upstream stage of the delayed Avalon memory model (dlymemory).
- Converts PDP-6 style memory-bus cycles from the processor (request cycle, read request, write request, write restart) into single Avalon-MM read/write transactions honouring waitrequest.
- Supports read-only, write-only and read-pause-write (read-modify-write) cycles.
- Returns address-acknowledge and read-restart strobes with the read data.

---
 rtl/membus_avalon_master_pkg.sv | 18 +
 rtl/membus_avalon_master.sv | 180 ++++++++++++++++++
 tb/tb_membus_avalon_master.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_avalon_master_pkg.sv
// Shared types for the membus-to-Avalon master and the delayed memory model.
package membus_avalon_master_pkg;

  localparam int AW_DEF = 18;
  localparam int DW_DEF = 36;

  // Memory word as seen by dlymemory
  typedef logic [DW_DEF-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT_WR,
    WR,
    DONE
  } state_e;

endpackage

// File: rtl/membus_avalon_master.sv
// Converts PDP-6 style memory-bus cycles (request, read, write restart) into
// single Avalon-MM read/write transactions, with read-pause-write support.
module membus_avalon_master
  import membus_avalon_master_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int WR_TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_rq_cyc,
  input  logic          i_rd_rq,
  input  logic          i_wr_rq,
  input  logic [AW-1:0] i_ma,
  input  logic [DW-1:0] i_mb_write,
  input  logic          i_wr_rs,
  output logic          o_addr_ack,
  output logic          o_rd_rs,
  output logic [DW-1:0] o_mb_read,
  output logic          o_busy,
  output logic          o_timeout,
  output logic [AW-1:0] o_address,
  output logic          o_read,
  output logic          o_write,
  output logic [DW-1:0] o_writedata,
  input  logic [DW-1:0] i_readdata,
  input  logic          i_waitrequest
);

  // Counter wide enough to hold WR_TIMEOUT; a zero timeout leaves it free-running.
  localparam int            CW      = $clog2(WR_TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = CW'(WR_TIMEOUT);
  localparam logic          TO_EN   = (WR_TIMEOUT != 0);

  state_e        state_q, state_d;
  logic          rq_cyc_q;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          addr_ack_q, addr_ack_d;
  logic          rd_rs_q, rd_rs_d;
  logic [DW-1:0] mb_read_q, mb_read_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [AW-1:0] address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [DW-1:0] writedata_q, writedata_d;
  logic          rq_rise;

  assign rq_rise = i_rq_cyc & ~rq_cyc_q;

  // Next-state and registered-output computation; strobes default low.
  always_comb begin
    state_d     = state_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    cnt_d       = '0;
    addr_ack_d  = 1'b0;
    rd_rs_d     = 1'b0;
    mb_read_d   = mb_read_q;
    timeout_d   = 1'b0;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;

    case (state_q)
      IDLE: begin
        if (rq_rise) begin
          address_d = i_ma;
          rd_req_d  = i_rd_rq;
          wr_req_d  = i_wr_rq;
          if (i_rd_rq) begin
            read_d  = 1'b1;
            state_d = RD;
          end else if (i_wr_rq) begin
            addr_ack_d = 1'b1;
            state_d    = WAIT_WR;
          end else begin
            state_d = DONE;
          end
        end
      end

      RD: begin
        // Completes even if the processor drops i_rq_cyc meanwhile.
        if (!i_waitrequest) begin
          mb_read_d  = i_readdata;
          read_d     = 1'b0;
          addr_ack_d = 1'b1;
          rd_rs_d    = 1'b1;
          state_d    = wr_req_q ? WAIT_WR : DONE;
        end
      end

      WAIT_WR: begin
        cnt_d = cnt_q + 1'b1;
        if (!i_rq_cyc) begin
          state_d = IDLE;
        end else if (i_wr_rs) begin
          writedata_d = i_mb_write;
          write_d     = 1'b1;
          state_d     = WR;
        end else if (TO_EN && (cnt_d == TO_LAST)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end

      WR: begin
        if (!i_waitrequest) begin
          write_d = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!i_rq_cyc) begin
          state_d = IDLE;
        end
      end

      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight Avalon request.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      rq_cyc_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      cnt_q       <= '0;
      addr_ack_q  <= 1'b0;
      rd_rs_q     <= 1'b0;
      mb_read_q   <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      rq_cyc_q    <= i_rq_cyc;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      cnt_q       <= cnt_d;
      addr_ack_q  <= addr_ack_d;
      rd_rs_q     <= rd_rs_d;
      mb_read_q   <= mb_read_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
    end
  end

  assign o_addr_ack  = addr_ack_q;
  assign o_rd_rs     = rd_rs_q;
  assign o_mb_read   = mb_read_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;
  assign o_address   = address_q;
  assign o_read      = read_q;
  assign o_write     = write_q;
  assign o_writedata = writedata_q;

endmodule

// File: tb/tb_membus_avalon_master.sv
// Bench for membus_avalon_master: small Avalon slave with programmable wait
// states, read/write scoreboards, and directed membus cycle sequences.
module tb_membus_avalon_master;

  localparam int AW = 18;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_rq_cyc, i_rd_rq, i_wr_rq, i_wr_rs;
  logic [AW-1:0] i_ma;
  logic [DW-1:0] i_mb_write;
  logic          o_addr_ack, o_rd_rs, o_busy, o_timeout, o_read, o_write;
  logic [DW-1:0] o_mb_read, o_writedata;
  logic [AW-1:0] o_address;
  logic [DW-1:0] i_readdata;
  logic          waitreq;

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [DW-1:0] mem [0:15];
  int            ws = 0;
  int            stall_cnt = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic          pl_we = 1'b0;
  logic [3:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic          overlap = 1'b0;

  logic [DW-1:0] rd_exp_q [$];
  logic [63:0]   wr_exp_q [$];

  membus_avalon_master #(.AW(AW), .DW(DW), .WR_TIMEOUT(8)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_rq_cyc     (i_rq_cyc),
    .i_rd_rq      (i_rd_rq),
    .i_wr_rq      (i_wr_rq),
    .i_ma         (i_ma),
    .i_mb_write   (i_mb_write),
    .i_wr_rs      (i_wr_rs),
    .o_addr_ack   (o_addr_ack),
    .o_rd_rs      (o_rd_rs),
    .o_mb_read    (o_mb_read),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_address    (o_address),
    .o_read       (o_read),
    .o_write      (o_write),
    .o_writedata  (o_writedata),
    .i_readdata   (i_readdata),
    .i_waitrequest(waitreq)
  );

  always #5 clk = ~clk;

  assign waitreq    = (stall_cnt < ws);
  assign i_readdata = mem[o_address[3:0]];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Avalon slave: zero-latency read data, writes land on accepted edges.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (o_write && !waitreq) begin
      mem[o_address[3:0]] <= o_writedata;
      wr_cnt <= wr_cnt + 1;
      if (wr_exp_q.size() == 0) check_val("wr_unexpected", 64'd1, 64'd0);
      else check_val("wr_addr_data", {10'd0, o_address, o_writedata}, wr_exp_q.pop_front());
    end
    if (o_read && !waitreq) rd_cnt <= rd_cnt + 1;
    if ((o_read || o_write) && waitreq) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  // Read-data scoreboard and read/write exclusivity monitor
  always @(posedge clk) begin
    #2;
    if (o_rd_rs) begin
      if (rd_exp_q.size() == 0) check_val("rd_unexpected", 64'd1, 64'd0);
      else check_val("rd_data", {28'd0, o_mb_read}, {28'd0, rd_exp_q.pop_front()});
    end
    if (o_read && o_write) overlap = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic start_cycle(input logic rd, input logic wr, input logic [AW-1:0] ma);
    i_rd_rq  = rd;
    i_wr_rq  = wr;
    i_ma     = ma;
    i_rq_cyc = 1'b1;
  endtask

  task automatic wait_rd_rs(input string tag);
    int n = 0;
    while (!o_rd_rs && n < 50) begin
      tick();
      n++;
    end
    if (!o_rd_rs) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_write_done(input string tag);
    int n = 0;
    while (o_write && n < 50) begin
      tick();
      n++;
    end
    if (o_write) check_val({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic end_cycle();
    i_rq_cyc = 1'b0;
    i_rd_rq  = 1'b0;
    i_wr_rq  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int r0, w0, k;
    i_reset_n  = 1'b0;
    i_rq_cyc   = 1'b0;
    i_rd_rq    = 1'b0;
    i_wr_rq    = 1'b0;
    i_ma       = '0;
    i_mb_write = '0;
    i_wr_rs    = 1'b0;

    // Reset state
    tick(); tick();
    check_val("rst_busy", o_busy, 0);
    check_val("rst_read", o_read, 0);
    check_val("rst_write", o_write, 0);
    check_val("rst_mb_read", o_mb_read, 0);
    check_val("rst_address", o_address, 0);
    i_reset_n = 1'b1;
    tick();

    // Read with wait states
    preload(4'd4, 36'd123);
    ws = 3;
    start_cycle(1'b1, 1'b0, 18'd4);
    rd_exp_q.push_back(36'd123);
    tick();
    check_val("rd_read_up", o_read, 1);
    check_val("rd_address", o_address, 18'd4);
    check_val("rd_busy", o_busy, 1);
    tick();
    check_val("rd_read_held", o_read, 1);
    wait_rd_rs("rd");
    check_val("rd_addr_ack", o_addr_ack, 1);
    check_val("rd_read_low", o_read, 0);
    tick();
    check_val("rd_rs_pulse", o_rd_rs, 0);
    check_val("rd_ack_pulse", o_addr_ack, 0);
    end_cycle();
    check_val("rd_idle", o_busy, 0);

    // Minimum read latency: two edges from i_rq_cyc rise
    preload(4'd3, 36'o700000000001);
    ws = 0;
    start_cycle(1'b1, 1'b0, 18'd3);
    rd_exp_q.push_back(36'o700000000001);
    tick();
    tick();
    check_val("lat_rd_rs", o_rd_rs, 1);
    end_cycle();

    // Write-only cycle
    ws = 2;
    start_cycle(1'b0, 1'b1, 18'd5);
    tick();
    check_val("wo_addr_ack", o_addr_ack, 1);
    check_val("wo_no_read", o_read, 0);
    tick();
    check_val("wo_ack_pulse", o_addr_ack, 0);
    tick();
    i_wr_rs    = 1'b1;
    i_mb_write = 36'o44556677;
    wr_exp_q.push_back({10'd0, 18'd5, 36'o44556677});
    tick();
    i_wr_rs = 1'b0;
    check_val("wo_write_up", o_write, 1);
    check_val("wo_writedata", o_writedata, 36'o44556677);
    tick();
    check_val("wo_write_held", o_write, 1);
    wait_write_done("wo");
    check_val("wo_mem", mem[5], 36'o44556677);
    end_cycle();
    check_val("wo_idle", o_busy, 0);

    // Read-modify-write
    preload(4'd5, 36'd321);
    r0 = rd_cnt;
    w0 = wr_cnt;
    ws = 1;
    start_cycle(1'b1, 1'b1, 18'd5);
    rd_exp_q.push_back(36'd321);
    wait_rd_rs("rmw");
    check_val("rmw_addr_ack", o_addr_ack, 1);
    tick();
    tick();
    check_val("rmw_waiting", o_busy, 1);
    i_wr_rs    = 1'b1;
    i_mb_write = 36'o777;
    wr_exp_q.push_back({10'd0, 18'd5, 36'o777});
    tick();
    i_wr_rs = 1'b0;
    check_val("rmw_write_up", o_write, 1);
    wait_write_done("rmw");
    check_val("rmw_mem", mem[5], 36'o777);
    check_val("rmw_nreads", rd_cnt - r0, 1);
    check_val("rmw_nwrites", wr_cnt - w0, 1);
    end_cycle();

    // Abort: i_rq_cyc drops during the read-pause, later i_wr_rs ignored
    preload(4'd6, 36'o1234);
    w0 = wr_cnt;
    ws = 0;
    start_cycle(1'b1, 1'b1, 18'd6);
    rd_exp_q.push_back(36'o1234);
    wait_rd_rs("abort");
    i_rq_cyc = 1'b0;
    tick();
    check_val("abort_idle", o_busy, 0);
    i_wr_rs    = 1'b1;
    i_mb_write = 36'o5555;
    tick();
    i_wr_rs = 1'b0;
    tick();
    check_val("abort_no_write", o_write, 0);
    check_val("abort_nwrites", wr_cnt - w0, 0);
    check_val("abort_busy", o_busy, 0);
    end_cycle();

    // Timeout: no write restart within 8 cycles of entering WAIT_WR
    w0 = wr_cnt;
    start_cycle(1'b0, 1'b1, 18'd8);
    tick();
    check_val("to_addr_ack", o_addr_ack, 1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (o_timeout) begin
        k = i;
        break;
      end
    end
    check_val("to_delay", k, 8);
    check_val("to_done_busy", o_busy, 1);
    tick();
    check_val("to_pulse", o_timeout, 0);
    check_val("to_still_done", o_busy, 1);
    end_cycle();
    check_val("to_idle", o_busy, 0);
    check_val("to_nwrites", wr_cnt - w0, 0);

    // Asynchronous reset during a stalled read
    ws = 100;
    start_cycle(1'b1, 1'b0, 18'd7);
    tick();
    tick();
    check_val("ar_read_up", o_read, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_val("ar_read", o_read, 0);
    check_val("ar_busy", o_busy, 0);
    check_val("ar_mb_read", o_mb_read, 0);
    i_rq_cyc = 1'b0;
    ws = 0;
    tick();
    i_reset_n = 1'b1;
    tick();
    tick();

    check_val("sb_rd_empty", rd_exp_q.size(), 0);
    check_val("sb_wr_empty", wr_exp_q.size(), 0);
    check_val("rd_wr_exclusive", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
